// File: rtl/rf_inj_pkg.sv
// Shared types and saturating helpers for the regfile score injector.
// The top module's build option INJ_STARVE_STALL_EN does not change anything in this package.
package rf_inj_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } inj_state_t;

  localparam int SCORE_REG_DEFAULT = 30;
  localparam int PEND_W_DEFAULT    = 16;

  // Saturate a wide signed value into the range of a 'width'-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic [63:0] clamp_unsigned(input logic signed [63:0] value,
                                                 input int width);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0) return '0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/rf_score_injector_lane_delta_counter.sv
// Net score change for one cycle of lane events: hits minus misses,
// where a lane reporting both in the same cycle cancels to zero.
module lane_delta_counter #(
  parameter int NUM_LANES = 5,
  parameter int DELTA_W   = $clog2(NUM_LANES + 1) + 1
) (
  input  logic [NUM_LANES-1:0]      hit,
  input  logic [NUM_LANES-1:0]      miss,
  output logic signed [DELTA_W-1:0] delta
);

  logic [NUM_LANES-1:0] eff_hit;
  logic [NUM_LANES-1:0] eff_miss;
  logic [DELTA_W-1:0]   n_hit;
  logic [DELTA_W-1:0]   n_miss;

  assign eff_hit  = hit & ~miss;
  assign eff_miss = miss & ~hit;

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_hit  = n_hit + DELTA_W'(eff_hit[i]);
      n_miss = n_miss + DELTA_W'(eff_miss[i]);
    end
    delta = $signed(n_hit - n_miss);
  end

endmodule

// File: rtl/rf_score_injector.sv
// Muxes mole-lane score updates into the regfile write port during CPU write-idle cycles.
// Define INJ_STARVE_STALL_EN to force a CPU stall after STARVE_LIMIT blocked cycles.
module rf_score_injector
  import rf_inj_pkg::*;
#(
  parameter int NUM_LANES    = 5,
  parameter int DATA_W       = 32,
  parameter int SCORE_REG    = SCORE_REG_DEFAULT,
  parameter int WIN_SCORE    = 12,
  parameter int PEND_W       = PEND_W_DEFAULT,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [4:0]               cpu_rd,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic [DATA_W-1:0]        score_cur,
  input  logic [NUM_LANES-1:0]     hit,
  input  logic [NUM_LANES-1:0]     miss,
  input  logic                     clear,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     cpu_stall,
  output logic signed [PEND_W-1:0] pending,
  output logic                     busy,
  output logic                     win
);

  localparam int DELTA_W = $clog2(NUM_LANES + 1) + 1;

  if (PEND_W < 2 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("rf_score_injector: PEND_W must be >= 2 and STARVE_LIMIT >= 1");
  end

  inj_state_t                state;
  inj_state_t                state_next;
  logic signed [DELTA_W-1:0] lane_delta;
  logic signed [DELTA_W-1:0] event_delta;
  logic signed [63:0]        pend_base;
  logic signed [PEND_W-1:0]  pending_next;
  logic [DATA_W-1:0]         inject_value;
  logic                      grant;
  logic                      zero_drop;
  logic                      inject;
  logic                      stall_active;

  lane_delta_counter #(
    .NUM_LANES(NUM_LANES),
    .DELTA_W  (DELTA_W)
  ) u_lane_delta (
    .hit  (hit),
    .miss (miss),
    .delta(lane_delta)
  );

  assign event_delta = win ? '0 : lane_delta;
  assign grant       = (state == IDLE) && (pending != '0) && (!cpu_we || stall_active);
  // A negative delta against a zero score cannot lower it further, so it is simply discarded.
  assign zero_drop   = grant && pending[PEND_W-1] && (score_cur == '0);
  assign inject      = grant && !zero_drop;
  assign busy        = (pending != '0) || (state != IDLE);

  always_comb begin
    pend_base    = grant ? 64'sd0 : 64'(pending);
    pending_next = PEND_W'(sat_signed(pend_base + 64'(event_delta), PEND_W));
    inject_value = DATA_W'(clamp_unsigned(64'($signed({1'b0, score_cur})) + 64'(pending),
                                          DATA_W));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) pending <= '0;
    else                pending <= pending_next;
  end

  always_ff @(posedge clk) begin
    if (reset || clear)                        win <= 1'b0;
    else if (score_cur >= DATA_W'(WIN_SCORE))  win <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_next;
  end

  // SETTLE gives the injected write one cycle to land before score_cur is trusted again.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inject) state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rf_we     = cpu_we;
    rf_rd     = cpu_rd;
    rf_wdata  = cpu_wdata;
    cpu_stall = 1'b0;
    if (inject) begin
      rf_we     = 1'b1;
      rf_rd     = 5'(SCORE_REG);
      rf_wdata  = inject_value;
      cpu_stall = stall_active;
    end
  end

`ifdef INJ_STARVE_STALL_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_count;
  logic             starve_inc;

  assign starve_inc = (state == IDLE) && (pending != '0) && cpu_we && !grant;

  // stall_active rises on the edge where the count reaches the limit, so the next cycle is granted.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      starve_count <= '0;
      stall_active <= 1'b0;
    end else if (grant) begin
      starve_count <= '0;
      stall_active <= 1'b0;
    end else if (starve_inc && (starve_count < CNT_W'(STARVE_LIMIT))) begin
      starve_count <= starve_count + CNT_W'(1);
      if (starve_count == CNT_W'(STARVE_LIMIT - 1)) stall_active <= 1'b1;
    end
  end
`else
  assign stall_active = 1'b0;
`endif

endmodule

// File: tb/tb_rf_score_injector.sv
// Directed bench for rf_score_injector with a per-cycle score/pending model;
// follows INJ_STARVE_STALL_EN so it matches whichever build it is compiled with.
module tb_rf_score_injector;

  localparam int  SCORE_REG    = 30;
  localparam int  WIN_SCORE    = 12;
  localparam int  STARVE_LIMIT = 8;
  localparam longint PEND_MAX  = 32767;
  localparam longint PEND_MIN  = -32768;
  localparam longint DATA_MAX  = 64'h0000_0000_FFFF_FFFF;
`ifdef INJ_STARVE_STALL_EN
  localparam bit  STARVE_EN    = 1'b1;
`else
  localparam bit  STARVE_EN    = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_we;
  logic [4:0]        cpu_rd;
  logic [31:0]       cpu_wdata;
  logic [31:0]       score_cur;
  logic [4:0]        hit;
  logic [4:0]        miss;
  logic              clear;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_wdata;
  logic              cpu_stall;
  logic signed [15:0] pending;
  logic              busy;
  logic              win;

  int tests_run    = 0;
  int tests_failed = 0;

  longint m_pend    = 0;
  bit     m_settle  = 1'b0;
  bit     m_stall   = 1'b0;
  bit     m_win     = 1'b0;
  int     m_blocked = 0;

  rf_score_injector dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_rd   (cpu_rd),
    .cpu_wdata(cpu_wdata),
    .score_cur(score_cur),
    .hit      (hit),
    .miss     (miss),
    .clear    (clear),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .cpu_stall(cpu_stall),
    .pending  (pending),
    .busy     (busy),
    .win      (win)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                               input logic [31:0] score, input logic [4:0] h,
                               input logic [4:0] m, input logic clr, input logic rst);
    @(posedge clk);
    #1;
    cpu_we    = we;
    cpu_rd    = rd;
    cpu_wdata = wd;
    score_cur = score;
    hit       = h;
    miss      = m;
    clear     = clr;
    reset     = rst;
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic [31:0] score, input logic [4:0] h, input logic [4:0] m);
    applyStimulus(1'b0, 5'd0, 32'd0, score, h, m, 1'b0, 1'b0);
  endtask

  // Score model: compare this cycle's outputs, then move to the state after the coming edge.
  always @(negedge clk) begin
    bit     g;
    bit     drop;
    bit     inj;
    longint sum;
    longint exp_wdata;
    int     d;
    g    = !m_settle && (m_pend != 0) && (!cpu_we || m_stall);
    drop = g && (m_pend < 0) && (score_cur == 32'd0);
    inj  = g && !drop;
    sum  = longint'(score_cur) + m_pend;
    exp_wdata = (sum < 0) ? 0 : ((sum > DATA_MAX) ? DATA_MAX : sum);

    checkOutput("rf_we",     rf_we,     inj ? 64'd1 : 64'(cpu_we));
    checkOutput("rf_rd",     rf_rd,     inj ? 64'(SCORE_REG) : 64'(cpu_rd));
    checkOutput("rf_wdata",  rf_wdata,  inj ? exp_wdata : 64'(cpu_wdata));
    checkOutput("cpu_stall", cpu_stall, inj ? 64'(m_stall) : 64'd0);
    checkOutput("pending",   pending,   m_pend);
    checkOutput("busy",      busy,      ((m_pend != 0) || m_settle) ? 64'd1 : 64'd0);
    checkOutput("win",       win,       64'(m_win));

    if (reset || clear) begin
      m_pend = 0; m_settle = 0; m_stall = 0; m_win = 0; m_blocked = 0;
    end else begin
      d = m_win ? 0 : ($countones(hit & ~miss) - $countones(miss & ~hit));
      if (g) begin
        m_blocked = 0;
        m_stall   = 0;
      end else if (!m_settle && (m_pend != 0) && cpu_we) begin
        m_blocked++;
        if (STARVE_EN && m_blocked >= STARVE_LIMIT) m_stall = 1;
      end
      m_pend = (g ? 0 : m_pend) + d;
      if (m_pend > PEND_MAX) m_pend = PEND_MAX;
      if (m_pend < PEND_MIN) m_pend = PEND_MIN;
      m_settle = inj;
      if (score_cur >= WIN_SCORE) m_win = 1;
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; cpu_we = 1'b0; cpu_rd = '0; cpu_wdata = '0;
    score_cur = '0; hit = '0; miss = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idleCycle(32'd3, 5'd0, 5'd0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_busy",    busy,    0);
    checkOutput("reset_win",     win,     0);
    checkOutput("reset_rf_we",   rf_we,   0);

    // Hits on lanes 0 and 2 commit 3+2 on the very next cycle.
    idleCycle(32'd3, 5'b00101, 5'd0);
    idleCycle(32'd3, 5'd0, 5'd0);
    checkOutput("a_pending",  pending,  2);
    checkOutput("a_rf_we",    rf_we,    1);
    checkOutput("a_rf_rd",    rf_rd,    30);
    checkOutput("a_rf_wdata", rf_wdata, 5);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("a_settle_busy",    busy,    1);
    checkOutput("a_settle_pending", pending, 0);
    checkOutput("a_settle_rf_we",   rf_we,   0);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("a_idle_busy", busy, 0);

    // Three misses against score 1 clamp at zero; then a drop against a zero score.
    idleCycle(32'd1, 5'd0, 5'b11010);
    idleCycle(32'd1, 5'd0, 5'd0);
    checkOutput("b_pending",  pending,  -3);
    checkOutput("b_rf_we",    rf_we,    1);
    checkOutput("b_rf_wdata", rf_wdata, 0);
    idleCycle(32'd0, 5'd0, 5'd0);
    idleCycle(32'd0, 5'd0, 5'b00011);
    idleCycle(32'd0, 5'd0, 5'd0);
    checkOutput("drop_pending", pending, -2);
    checkOutput("drop_rf_we",   rf_we,   0);
    idleCycle(32'd0, 5'd0, 5'd0);
    checkOutput("drop_cleared", pending, 0);
    checkOutput("drop_no_settle", busy, 0);

    // CPU keeps writing register 5 while a +1 is pending.
    applyStimulus(1'b1, 5'd5, 32'hAA, 32'd0, 5'b00001, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 5'd5, 32'hAA, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
`ifdef INJ_STARVE_STALL_EN
      if (i == 8) checkOutput("starve_no_stall_yet", cpu_stall, 0);
      if (i == 9) begin
        checkOutput("starve_stall",    cpu_stall, 1);
        checkOutput("starve_rf_rd",    rf_rd,     30);
        checkOutput("starve_rf_wdata", rf_wdata,  1);
      end
      if (i == 10) begin
        checkOutput("replay_rf_rd",    rf_rd,     5);
        checkOutput("replay_rf_wdata", rf_wdata,  32'hAA);
        checkOutput("replay_stall",    cpu_stall, 0);
      end
`else
      if (i == 9) begin
        checkOutput("nostall_stall", cpu_stall, 0);
        checkOutput("nostall_rf_rd", rf_rd,     5);
      end
      if (i == 12) checkOutput("nostall_pending", pending, 1);
`endif
    end
    idleCycle(32'd0, 5'd0, 5'd0);
`ifndef INJ_STARVE_STALL_EN
    checkOutput("nostall_late_we",     rf_we,    1);
    checkOutput("nostall_late_wdata",  rf_wdata, 1);
`endif
    idleCycle(32'd1, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd1, 5'd0, 5'd0, 1'b1, 1'b0);

    // Cancelling hit/miss on lane 2 during a grant leaves nothing behind.
    idleCycle(32'd4, 5'b00010, 5'd0);
    idleCycle(32'd4, 5'b00100, 5'b00100);
    checkOutput("cancel_rf_wdata", rf_wdata, 5);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("cancel_pending", pending, 0);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("cancel_busy", busy, 0);

    // Hit during a grant: second injection after SETTLE uses the updated score.
    idleCycle(32'd4, 5'b00001, 5'd0);
    idleCycle(32'd4, 5'b01000, 5'd0);
    checkOutput("regrant_first", rf_wdata, 5);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("regrant_settle_pending", pending, 1);
    checkOutput("regrant_settle_we",      rf_we,   0);
    idleCycle(32'd5, 5'd0, 5'd0);
    checkOutput("regrant_second_we",    rf_we,    1);
    checkOutput("regrant_second_wdata", rf_wdata, 6);
    idleCycle(32'd6, 5'd0, 5'd0);

    applyStimulus(1'b1, 5'd30, 32'd9, 32'd6, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("cpu_score_rd",    rf_rd,    30);
    checkOutput("cpu_score_wdata", rf_wdata, 9);

    // Win is registered, sticky, and freezes the event path until clear.
    idleCycle(32'd11, 5'd0, 5'd0);
    checkOutput("win_below", win, 0);
    idleCycle(32'd12, 5'd0, 5'd0);
    checkOutput("win_same_cycle", win, 0);
    idleCycle(32'd12, 5'b11111, 5'd0);
    checkOutput("win_set", win, 1);
    idleCycle(32'd12, 5'd0, 5'd0);
    checkOutput("win_hits_ignored", pending, 0);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd12, 5'b11111, 5'd0, 1'b1, 1'b0);
    idleCycle(32'd0, 5'd0, 5'd0);
    checkOutput("clear_win",     win,     0);
    checkOutput("clear_pending", pending, 0);

    // Reset during SETTLE returns to plain passthrough.
    idleCycle(32'd0, 5'b00001, 5'd0);
    idleCycle(32'd0, 5'd0, 5'd0);
    checkOutput("pre_reset_wdata", rf_wdata, 1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd1, 5'b00001, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd7, 32'h55, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("post_reset_busy",    busy,      0);
    checkOutput("post_reset_pending", pending,   0);
    checkOutput("post_reset_rf_rd",   rf_rd,     7);
    checkOutput("post_reset_wdata",   rf_wdata,  32'h55);
    checkOutput("post_reset_stall",   cpu_stall, 0);

`ifndef INJ_STARVE_STALL_EN
    // With no forced stall a busy CPU lets pending run into both saturation limits.
    for (int i = 0; i < 6560; i++)
      applyStimulus(1'b1, 5'd3, 32'd0, 32'd0, 5'b11111, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("sat_pos", pending, PEND_MAX);
    applyStimulus(1'b1, 5'd3, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6560; i++)
      applyStimulus(1'b1, 5'd3, 32'd0, 32'd0, 5'd0, 5'b11111, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("sat_neg", pending, PEND_MIN);
`endif
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idleCycle(32'd0, 5'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
